// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage MIPS pipeline: RAW scoreboard, multiplier/HI-LO interlock, wrong-path squash.
// Optional build macro HAZARD_FORWARD_EN adds EX-stage forwarding selects and relaxes the data-hazard rule.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_we_reg,
  input  logic [4:0]  id_wa,
  input  logic        id_load,
  input  logic        id_mult,
  input  logic        id_mfhilo,
  input  logic        id_jump,
  input  logic        ex_redirect,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        mul_busy,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] wa;
    logic       load;
    logic [4:0] rs;
    logic [4:0] rt;
  } sb_entry_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT);

  // Register $0 is hardwired, so a write to it never creates a dependency.
  function automatic logic match(input sb_entry_t s, input logic [4:0] r);
    return s.v && (s.wa == r) && (r != 5'd0);
  endfunction

  sb_entry_t  sb_id, sb_ex, sb_mem, sb_wb;
  logic [3:0] mul_cnt;
  logic       hit_ex, hit_mem, hit_wb;
  logic       data_hz, mul_hz, stall;

  // Unused sources are stored as $0 so they can never produce a forwarding hit.
  always_comb begin
    sb_id.v    = id_we_reg && (id_wa != 5'd0);
    sb_id.wa   = id_wa;
    sb_id.load = id_load;
    sb_id.rs   = id_use_rs ? id_rs : 5'd0;
    sb_id.rt   = id_use_rt ? id_rt : 5'd0;
  end

  always_comb begin
    hit_ex  = (id_use_rs && match(sb_ex,  id_rs)) || (id_use_rt && match(sb_ex,  id_rt));
    hit_mem = (id_use_rs && match(sb_mem, id_rs)) || (id_use_rt && match(sb_mem, id_rt));
    hit_wb  = (id_use_rs && match(sb_wb,  id_rs)) || (id_use_rt && match(sb_wb,  id_rt));
  end

`ifdef HAZARD_FORWARD_EN
  // The RF has no write-through, so a WB-stage producer still has to be waited out.
  assign data_hz = (hit_ex && sb_ex.load) || hit_wb;

  // NOTE: every variable in an always_comb gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    fwd_a = 2'b00;
    if (match(sb_mem, sb_ex.rs))     fwd_a = 2'b01;
    else if (match(sb_wb, sb_ex.rs)) fwd_a = 2'b10;
    fwd_b = 2'b00;
    if (match(sb_mem, sb_ex.rt))     fwd_b = 2'b01;
    else if (match(sb_wb, sb_ex.rt)) fwd_b = 2'b10;
  end
`else
  assign data_hz = hit_ex || hit_mem || hit_wb;
  assign fwd_a   = 2'b00;
  assign fwd_b   = 2'b00;
`endif

  assign mul_busy = (mul_cnt != 4'd0);
  assign mul_hz   = mul_busy && (id_mult || id_mfhilo);
  // A redirect kills the ID instruction, so its hazards no longer matter.
  assign stall    = (data_hz || mul_hz) && !ex_redirect;

  assign pc_en       = !stall;
  assign ifid_en     = !stall;
  assign idex_bubble = stall || ex_redirect;
  assign ifid_flush  = ex_redirect || (id_jump && !stall);

  // Entry fields that only some configurations consume.
  logic unused_fields;
  assign unused_fields = ^{hit_mem, sb_mem.load, sb_mem.rs, sb_mem.rt,
                           sb_wb.load, sb_wb.rs, sb_wb.rt, sb_ex.rs, sb_ex.rt};

  // NOTE: sequential state uses non-blocking assignments so the WB<=MEM<=EX shift reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_ex     <= '0;
      sb_mem    <= '0;
      sb_wb     <= '0;
      mul_cnt   <= 4'd0;
      stall_cnt <= 16'd0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= idex_bubble ? sb_entry_t'('0) : sb_id;

      if (id_mult && !stall && !ex_redirect)
        mul_cnt <= MUL_LOAD;
      else if (mul_cnt != 4'd0)
        mul_cnt <= mul_cnt - 4'd1;

      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues hand-computed per-cycle expectations, a monitor checks them.
// Expectations follow the HAZARD_FORWARD_EN build setting.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, id_wa = '0;
  logic        id_use_rs = 0, id_use_rt = 0, id_we_reg = 0, id_load = 0;
  logic        id_mult = 0, id_mfhilo = 0, id_jump = 0, ex_redirect = 0;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, mul_busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_we_reg(id_we_reg), .id_wa(id_wa), .id_load(id_load), .id_mult(id_mult),
    .id_mfhilo(id_mfhilo), .id_jump(id_jump), .ex_redirect(ex_redirect),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .mul_busy(mul_busy), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, we;
    logic [4:0] wa;
    logic       load, mult, mfhilo, jump, redirect;
  } stim_t;

  typedef struct packed {
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, mul_busy;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t e_(logic pc, logic fe, logic fl, logic bb, logic mb,
                              logic [1:0] fa, logic [1:0] fb, logic [15:0] sc);
    exp_t e;
    e.pc_en = pc; e.ifid_en = fe; e.ifid_flush = fl; e.idex_bubble = bb;
    e.mul_busy = mb; e.fwd_a = fa; e.fwd_b = fb; e.stall_cnt = sc;
    return e;
  endfunction

  function automatic exp_t ok_(logic [15:0] sc);   return e_(1, 1, 0, 0, 0, 2'b00, 2'b00, sc); endfunction
  function automatic exp_t okb_(logic [15:0] sc);  return e_(1, 1, 0, 0, 1, 2'b00, 2'b00, sc); endfunction
  function automatic exp_t stl_(logic [15:0] sc);  return e_(0, 0, 0, 1, 0, 2'b00, 2'b00, sc); endfunction
  function automatic exp_t stlb_(logic [15:0] sc); return e_(0, 0, 0, 1, 1, 2'b00, 2'b00, sc); endfunction

  function automatic stim_t nop_s();
    stim_t s = '0;
    return s;
  endfunction
  function automatic stim_t wr_s(logic [4:0] wa, logic ld);
    stim_t s = '0;
    s.we = 1'b1; s.wa = wa; s.load = ld;
    return s;
  endfunction
  function automatic stim_t rd_s(logic [4:0] rs, logic urs, logic [4:0] rt, logic urt);
    stim_t s = '0;
    s.rs = rs; s.use_rs = urs; s.rt = rt; s.use_rt = urt;
    return s;
  endfunction
  function automatic stim_t mult_s();
    stim_t s = '0;
    s.mult = 1'b1;
    return s;
  endfunction
  function automatic stim_t mfhi_s();
    stim_t s = '0;
    s.mfhilo = 1'b1; s.we = 1'b1; s.wa = 5'd9;
    return s;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // One ID-stage cycle: inputs change just after the edge, expectation queued for the monitor.
  task automatic cyc(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst = s.rst; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
    id_we_reg = s.we; id_wa = s.wa; id_load = s.load; id_mult = s.mult;
    id_mfhilo = s.mfhilo; id_jump = s.jump; ex_redirect = s.redirect;
    exp_q.push_back(e);
  endtask

  task automatic rst_cyc();
    stim_t s = nop_s();
    s.rst = 1'b1;
    cyc(s, ok_(0));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc_en",       16'(pc_en),       16'(e.pc_en));
        check("ifid_en",     16'(ifid_en),     16'(e.ifid_en));
        check("ifid_flush",  16'(ifid_flush),  16'(e.ifid_flush));
        check("idex_bubble", 16'(idex_bubble), 16'(e.idex_bubble));
        check("mul_busy",    16'(mul_busy),    16'(e.mul_busy));
        check("fwd_a",       16'(fwd_a),       16'(e.fwd_a));
        check("fwd_b",       16'(fwd_b),       16'(e.fwd_b));
        check("stall_cnt",   stall_cnt,        e.stall_cnt);
      end
    end
  end

  initial begin : driver
    stim_t s;
    rst_cyc();
    rst_cyc();

    // Reset asserted mid-stall with the multiplier busy.
    cyc(nop_s(), ok_(0));
    cyc(mult_s(), ok_(0));
    cyc(wr_s(5'd5, 1'b1), okb_(0));
    s = rd_s(5'd5, 1'b1, 5'd0, 1'b0);
    cyc(s, stlb_(0));
    s.rst = 1'b1;
    cyc(s, ok_(0));
    cyc(nop_s(), ok_(0));

    // ALU producer of $3 followed by a consumer via rs.
    rst_cyc();
    cyc(wr_s(5'd3, 1'b0), ok_(0));
    s = rd_s(5'd3, 1'b1, 5'd0, 1'b0);
    s.we = 1'b1; s.wa = 5'd4;
`ifdef HAZARD_FORWARD_EN
    cyc(s, ok_(0));
    cyc(nop_s(), e_(1, 1, 0, 0, 0, 2'b01, 2'b00, 0));
    cyc(nop_s(), ok_(0));
    // Two writers of $3 in flight: the younger (MEM) one wins.
    rst_cyc();
    cyc(wr_s(5'd3, 1'b0), ok_(0));
    cyc(wr_s(5'd3, 1'b0), ok_(0));
    cyc(rd_s(5'd3, 1'b1, 5'd0, 1'b0), ok_(0));
    cyc(nop_s(), e_(1, 1, 0, 0, 0, 2'b01, 2'b00, 0));
    // A producer sitting in WB still stalls.
    rst_cyc();
    cyc(wr_s(5'd6, 1'b0), ok_(0));
    cyc(nop_s(), ok_(0));
    cyc(nop_s(), ok_(0));
    cyc(rd_s(5'd0, 1'b0, 5'd6, 1'b1), stl_(0));
    cyc(rd_s(5'd0, 1'b0, 5'd6, 1'b1), ok_(1));
    cyc(nop_s(), ok_(1));
`else
    cyc(s, stl_(0));
    cyc(s, stl_(1));
    cyc(s, stl_(2));
    cyc(s, ok_(3));
    cyc(nop_s(), ok_(3));
`endif

    // Load of $5 followed by a consumer via rt.
    rst_cyc();
    cyc(wr_s(5'd5, 1'b1), ok_(0));
    s = rd_s(5'd0, 1'b0, 5'd5, 1'b1);
`ifdef HAZARD_FORWARD_EN
    cyc(s, stl_(0));
    cyc(s, ok_(1));
    cyc(nop_s(), e_(1, 1, 0, 0, 0, 2'b00, 2'b10, 1));
`else
    cyc(s, stl_(0));
    cyc(s, stl_(1));
    cyc(s, stl_(2));
    cyc(s, ok_(3));
    cyc(nop_s(), ok_(3));
`endif

    // Writes to $0 never create a hazard.
    rst_cyc();
    cyc(wr_s(5'd0, 1'b1), ok_(0));
    cyc(rd_s(5'd0, 1'b1, 5'd0, 1'b1), ok_(0));
    cyc(nop_s(), ok_(0));

    // mult, one unrelated instruction, then mfhi.
    rst_cyc();
    cyc(mult_s(), ok_(0));
    cyc(nop_s(), okb_(0));
    cyc(mfhi_s(), stlb_(0));
    cyc(mfhi_s(), stlb_(1));
    cyc(mfhi_s(), ok_(2));
    cyc(nop_s(), ok_(2));

    // Back-to-back mult: second waits for the counter, then reloads it.
    rst_cyc();
    cyc(mult_s(), ok_(0));
    cyc(mult_s(), stlb_(0));
    cyc(mult_s(), stlb_(1));
    cyc(mult_s(), stlb_(2));
    cyc(mult_s(), ok_(3));
    cyc(nop_s(), okb_(3));

    // Plain jump squashes one slot.
    rst_cyc();
    s = nop_s(); s.jump = 1'b1;
    cyc(s, e_(1, 1, 1, 0, 0, 2'b00, 2'b00, 0));

    // Jump held back by a load-use stall: flush only once the stall clears.
    rst_cyc();
    cyc(wr_s(5'd7, 1'b1), ok_(0));
    s = rd_s(5'd7, 1'b1, 5'd0, 1'b0); s.jump = 1'b1;
`ifdef HAZARD_FORWARD_EN
    cyc(s, stl_(0));
    cyc(s, e_(1, 1, 1, 0, 0, 2'b00, 2'b00, 1));
`else
    cyc(s, stl_(0));
    cyc(s, stl_(1));
    cyc(s, stl_(2));
    cyc(s, e_(1, 1, 1, 0, 0, 2'b00, 2'b00, 3));
`endif

    // Redirect overrides a data hazard and a jump in the same cycle.
    rst_cyc();
    cyc(wr_s(5'd7, 1'b1), ok_(0));
    s = rd_s(5'd7, 1'b1, 5'd0, 1'b0); s.jump = 1'b1; s.redirect = 1'b1;
    cyc(s, e_(1, 1, 1, 1, 0, 2'b00, 2'b00, 0));
    cyc(nop_s(), ok_(0));

    // A mult squashed by a redirect must not occupy the multiplier.
    s = mult_s(); s.redirect = 1'b1;
    cyc(s, e_(1, 1, 1, 1, 0, 2'b00, 2'b00, 0));
    cyc(nop_s(), ok_(0));

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    check("queue_drain", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
